// File: rtl/mole_spawner_if.sv
// Control/strobe bundle between the round sequencer and its neighbours
// (button front end drives start/stop, board_state consumes load/loadval).
interface mole_spawner_if;
    logic       start;
    logic       stop;
    logic       load;
    logic [4:0] loadval;
    logic [7:0] round;
    logic       game_active;
    logic       game_over;

    modport master (
        input  start,
        input  stop,
        output load,
        output loadval,
        output round,
        output game_active,
        output game_over
    );

    modport slave (
        output start,
        output stop,
        input  load,
        input  loadval,
        input  round,
        input  game_active,
        input  game_over
    );
endinterface

// File: rtl/mole_spawner.sv
// Round sequencer: one LFSR mole pattern per round, then a clearing load and game over.
// Optional feature: define MOLE_LIMIT_EN to cap every spawn pattern at two moles.
module mole_spawner #(
    parameter logic [31:0] ROUND_TICKS = 32'd50_000_000,
    parameter int unsigned NUM_ROUNDS  = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic            clk,
    input logic            rst_n,
    mole_spawner_if.master bus
);

    // SPAWN and the first WAIT cycle consume two ticks of the round period.
    localparam logic [31:0] TMR_RELOAD = ROUND_TICKS - 32'd2;
    localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS);
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] tmr;
    logic [15:0] lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [4:0] limit_moles(input logic [4:0] pat);
`ifdef MOLE_LIMIT_EN
        logic [4:0] first;
        logic [4:0] rest;
        first = pat & (~pat + 5'd1);
        rest  = pat ^ first;
        return first | (rest & (~rest + 5'd1));
`else
        return pat;
`endif
    endfunction

    // An all-zero candidate would be indistinguishable from the clear load.
    function automatic logic [4:0] spawn_pattern(input logic [4:0] raw);
        return limit_moles((raw == 5'd0) ? 5'd1 : raw);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            tmr             <= '0;
            lfsr            <= LFSR_SEED;
            bus.load        <= 1'b0;
            bus.loadval     <= '0;
            bus.round       <= '0;
            bus.game_active <= 1'b0;
            bus.game_over   <= 1'b0;
        end else begin
            bus.load    <= 1'b0;
            bus.loadval <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        bus.game_over   <= 1'b1;
                        bus.game_active <= 1'b0;
                    end
                    if (bus.start && !bus.stop) begin
                        bus.round       <= '0;
                        bus.game_over   <= 1'b0;
                        bus.game_active <= 1'b0;
                        state           <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (bus.stop) begin
                        state <= S_CLEAR;
                    end else begin
                        bus.load        <= 1'b1;
                        bus.loadval     <= spawn_pattern(lfsr[4:0]);
                        lfsr            <= lfsr_next(lfsr);
                        bus.round       <= bus.round + 8'd1;
                        bus.game_active <= 1'b1;
                        tmr             <= TMR_RELOAD;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.stop) begin
                        state <= S_CLEAR;
                    end else if (tmr == 32'd0) begin
                        state <= (bus.round < LAST_ROUND) ? S_SPAWN : S_CLEAR;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_CLEAR: begin
                    bus.load        <= 1'b1;
                    bus.game_active <= 1'b1;
                    state           <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: directed test-plan scenarios plus randomized start/stop/reset,
// checked every cycle against an event-scheduling model of the round sequencer.
module tb_mole_spawner;
    localparam int RT = 4;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    mole_spawner_if bus ();
    mole_spawner_if bus_a ();
    mole_spawner_if bus_b ();

    assign bus.start   = start;
    assign bus.stop    = stop;
    assign bus_a.start = start;
    assign bus_a.stop  = stop;
    assign bus_b.start = start;
    assign bus_b.stop  = stop;

    mole_spawner #(.ROUND_TICKS(32'd4), .NUM_ROUNDS(NR), .LFSR_SEED(16'hACE1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    mole_spawner #(.ROUND_TICKS(32'd4), .NUM_ROUNDS(NR), .LFSR_SEED(16'h0020))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mole_spawner #(.ROUND_TICKS(32'd4), .NUM_ROUNDS(NR), .LFSR_SEED(16'h001F))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a pending event (spawn or clear) scheduled at an absolute cycle.
    int          ecyc = 0;
    bit          pend = 1'b0;
    bit          pend_clear = 1'b0;
    int          t_ev = 0;
    int          done_at = -1;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [7:0]  m_round = '0;
    logic        m_load = 1'b0;
    logic [4:0]  m_lv = '0;
    logic        m_act = 1'b0;
    logic        m_over = 1'b0;

    function automatic logic [4:0] model_pattern(input logic [15:0] st);
        logic [4:0] p;
        logic [4:0] r;
        int         n;
        p = st[4:0];
        if (p == 5'd0) p = 5'd1;
`ifdef MOLE_LIMIT_EN
        r = '0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (p[i] && n < 2) begin
                r[i] = 1'b1;
                n++;
            end
        end
        p = r;
`else
        r = p;
        n = 0;
`endif
        return p;
    endfunction

    always @(posedge clk) begin
        bit was_pend;
        ecyc++;
        m_load = 1'b0;
        m_lv   = '0;
        if (!rst_n) begin
            pend    = 1'b0;
            done_at = -1;
            m_lfsr  = 16'hACE1;
            m_round = '0;
            m_act   = 1'b0;
            m_over  = 1'b0;
        end else begin
            was_pend = pend;
            if (pend && stop && (pend_clear ? (ecyc < t_ev) : (ecyc <= t_ev))) begin
                pend_clear = 1'b1;
                t_ev       = ecyc + 1;
            end else if (pend && t_ev == ecyc) begin
                m_load = 1'b1;
                m_act  = 1'b1;
                if (!pend_clear) begin
                    m_lv       = model_pattern(m_lfsr);
                    m_lfsr     = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
                    m_round    = m_round + 8'd1;
                    pend_clear = (int'(m_round) >= NR);
                    t_ev       = ecyc + RT;
                end else begin
                    pend    = 1'b0;
                    done_at = ecyc + 1;
                end
            end
            if (done_at == ecyc) begin
                m_act  = 1'b0;
                m_over = 1'b1;
            end
            if (!was_pend && start && !stop) begin
                m_round    = '0;
                m_over     = 1'b0;
                m_act      = 1'b0;
                pend       = 1'b1;
                pend_clear = 1'b0;
                t_ev       = ecyc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model load", int'(bus.load), int'(m_load));
            chk("model loadval", int'(bus.loadval), int'(m_lv));
            chk("model round", int'(bus.round), int'(m_round));
            chk("model game_active", int'(bus.game_active), int'(m_act));
            chk("model game_over", int'(bus.game_over), int'(m_over));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " load"}, int'(bus.load), 0);
        chk({tag, " loadval"}, int'(bus.loadval), 0);
        chk({tag, " round"}, int'(bus.round), 0);
        chk({tag, " game_active"}, int'(bus.game_active), 0);
        chk({tag, " game_over"}, int'(bus.game_over), 0);
    endtask

    initial begin
        int rnd;
        int act;
        int ovr;
        logic [4:0] exp_b;
        // Reset held for two edges
        step();
        cmp_en = 1'b1;
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk_zero("idle");

        // Full game: spawns at 1, 5, 9, clear at 13, game over from 14
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            rnd = (c >= 9) ? 3 : (c >= 5) ? 2 : (c >= 1) ? 1 : 0;
            act = (c >= 1 && c < 14) ? 1 : 0;
            ovr = (c >= 14) ? 1 : 0;
            chk($sformatf("g1 load c%0d", c), int'(bus.load),
                (c == 1 || c == 5 || c == 9 || c == 13) ? 1 : 0);
            chk($sformatf("g1 round c%0d", c), int'(bus.round), rnd);
            chk($sformatf("g1 active c%0d", c), int'(bus.game_active), act);
            chk($sformatf("g1 over c%0d", c), int'(bus.game_over), ovr);
            if (c == 1) begin
                chk("g1 loadval 1", int'(bus.loadval), 1);
                chk("seed0020 loadval", int'(bus_a.loadval), 1);
                chk("seed0020 load", int'(bus_a.load), 1);
`ifdef MOLE_LIMIT_EN
                exp_b = 5'b00011;
`else
                exp_b = 5'b11111;
`endif
                chk("seed001F loadval", int'(bus_b.loadval), int'(exp_b));
            end
            if (c == 5)  chk("g1 loadval 2", int'(bus.loadval), 16);
            if (c == 9)  chk("g1 loadval 3", int'(bus.loadval), 24);
            if (c == 13) chk("g1 clear loadval", int'(bus.loadval), 0);
        end

        // Restart from DONE, stop two cycles after second spawn
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        chk("g2 spawn2 load", int'(bus.load), 1);
        chk("g2 spawn2 round", int'(bus.round), 2);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("g2 clear load", int'(bus.load), 1);
        chk("g2 clear loadval", int'(bus.loadval), 0);
        chk("g2 clear round", int'(bus.round), 2);
        step();
        chk("g2 over", int'(bus.game_over), 1);
        chk("g2 active", int'(bus.game_active), 0);
        chk("g2 round hold", int'(bus.round), 2);

        // start during WAIT ignored; reset mid-WAIT
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("g3 spacing load", int'(bus.load), 1);
        chk("g3 spacing round", int'(bus.round), 2);
        step();
        rst_n = 1'b0;
        step();
        chk_zero("midwait reset");
        rst_n = 1'b1;
        step();

        // start+stop together in IDLE does nothing
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_zero("start+stop idle");
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mole_spawner.md
# mole_spawner

Round sequencer that sits directly upstream of `board_state`. It produces that block's `load`/`loadval` strobes: one pseudo-random mole pattern per round, at a fixed round period, for a fixed number of rounds. After the last round it issues a clearing load and reports game over. It runs on the system clock and gets its start and stop pulses from the button/control front end.

## Interface
- `ROUND_TICKS`, default 50_000_000: clock cycles between consecutive load pulses; legal range 2 to 2^32-1.
- `NUM_ROUNDS`, default 30: spawn pulses per game; legal range 1 to 255.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: active-high pulse that begins a game.
- `stop` input 1: active-high pulse that aborts a running game.
- `load` output 1: active-high one-cycle pulse to `board_state`.
- `loadval` output 5: mole pattern, valid while `load`=1; 0 at all other times.
- `round` output 8: number of spawns issued in the current or last game.
- `game_active` output 1: high from the first spawn up to and including the clear pulse.
- `game_over` output 1: high after a game ends, until the next `start` or reset.

## Operation
- States:
  - IDLE: no game has run since reset.
  - SPAWN: one cycle.
  - WAIT: counts out the round period.
  - CLEAR: one cycle.
  - DONE: game finished.
- Reset (`rst_n`=0 at an edge, from any state, including mid-WAIT):
  - state goes to IDLE;
  - `load`, `loadval`, `round`, `game_active` and `game_over` all go to 0;
  - the LFSR is loaded with `LFSR_SEED`;
  - the period timer is cleared.
- IDLE or DONE with `start`=1 and `stop`=0:
  - `round` is set to 0 and `game_over` to 0;
  - go to SPAWN.
- SPAWN:
  - `load`=1;
  - `loadval` = LFSR[4:0], or 5'b00001 if LFSR[4:0]=0;
  - the LFSR advances one step;
  - `round` increments by 1;
  - go to WAIT.
- WAIT:
  - when the period expires and `round`<`NUM_ROUNDS`, go to SPAWN;
  - when the period expires and `round`=`NUM_ROUNDS`, go to CLEAR.
- CLEAR:
  - `load`=1, `loadval`=0 (empties the board);
  - go to DONE.
- DONE: `game_over`=1 and `round` holds.
- `stop`=1 in SPAWN or WAIT: go to CLEAR at the next edge; `round` holds.
- `stop` and `start` asserted together: `stop` wins. In IDLE or DONE this means nothing happens.
- `start` while a game is active is ignored.
- `stop` in IDLE, CLEAR or DONE is ignored.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right;
  - advances only in SPAWN;
  - its state persists across games and is reset only by `rst_n`.

## Timing
- All outputs are registered. Nothing flows combinationally from input to output.
- A `start` sampled at edge k gives `load`=1 in the cycle after edge k+1 (one-cycle latency through SPAWN).
- Successive `load` pulses within a game are exactly `ROUND_TICKS` cycles apart, measured rising to rising.
- The clear pulse follows the last spawn by `ROUND_TICKS` cycles.
- A `stop` sampled at edge k gives the clear pulse in the cycle after edge k+1.
- `game_active` falls, and `game_over` rises, on the edge after the clear pulse.
- `round` updates on the same edge that raises the spawn `load`.

## Configuration
- `MOLE_LIMIT_EN` defined: when the candidate pattern has more than two bits set, only its two lowest set bits are kept. At most 2 moles are up at once.
- `MOLE_LIMIT_EN` undefined: the candidate pattern passes through unchanged, so 1 to 5 moles may be up.

## Test plan
All scenarios use `ROUND_TICKS`=4 and `NUM_ROUNDS`=3.
1. Hold `rst_n`=0 for 2 edges, then release -> all outputs 0. Repeat with `rst_n`=0 asserted mid-WAIT -> all outputs 0 at that edge and the state returns to IDLE.
2. Pulse `start` at edge 0:
   - `load` pulses at cycles 1, 5 and 9, with `round` = 1, 2, 3 at those cycles;
   - `load`=1 with `loadval`=0 at cycle 13;
   - `game_over`=1 and `game_active`=0 from cycle 14.
3. Pulse `stop` 2 cycles after the second spawn -> clear pulse on the next cycle, `round` holds at 2, then `game_over`=1.
4. During WAIT, pulse `start` alone -> ignored, spacing unchanged. In IDLE, pulse `start` and `stop` together -> stays IDLE, no `load`.
5. `LFSR_SEED`=16'h0020 -> first spawn gives `loadval`=5'b00001.
6. `LFSR_SEED`=16'h001F -> first `loadval`=5'b11111 with the macro undefined, 5'b00011 with `MOLE_LIMIT_EN` defined.
